wbram_decode: RTL and testbench
===============================

# wbram_decode

Pipelined Wishbone slave RAM with address-window decode, sitting directly downstream of the MMU's physical memory port. Accepts the MMU's translated requests, performs single-word reads/writes on a local 2^MAW-word array, and returns in-order ack, or err for out-of-window addresses and bus-protocol violations. Configurable ack latency and periodic stall injection exercise the MMU's pipelined return path.

## Interface
- AW, 28, width of the incoming word address.
- MAW, 15, log2 of RAM depth in 32-bit words.
- BASE, 1, required value of address bits [AW-1:MAW]; width AW-MAW.
- ACK_DELAY, 1, cycles from request acceptance to ack/err; legal 1..4.
- STALL_PERIOD, 0, 0 = never stall; N ≥ 2 = stall one cycle in every N while cyc is high.
- i_clk  in  1  sole clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_wb_cyc  in  1  bus cycle.
- i_wb_stb  in  1  request strobe.
- i_wb_we  in  1  1 = write.
- i_wb_addr  in  AW  word address.
- i_wb_data  in  32  write data.
- o_wb_stall  out  1  request not accepted this cycle.
- o_wb_ack  out  1  request completed.
- o_wb_err  out  1  request or protocol fault.
- o_wb_data  out  32  read data, valid with o_wb_ack.

## Operation
- States: IDLE (cyc low), BUSY (cyc high, no fault), FAULT (fault seen, waiting for cyc to drop).
- IDLE→BUSY when cyc rises; BUSY→IDLE when cyc falls; BUSY→FAULT on accepting an out-of-window request; FAULT→IDLE when cyc falls.
- Accept = cyc & stb & !o_wb_stall. In-window (addr[AW-1:MAW]==BASE): write commits to RAM on the acceptance edge; read samples RAM at addr[MAW-1:0] on the acceptance edge.
- Out-of-window accept: no RAM access; entry tagged err; state→FAULT.
- Each accept pushes {valid, err, data} into an ACK_DELAY-deep shift pipeline; pipe output drives ack (valid & !err) or err (valid & err), never both.
- FAULT: o_wb_stall=1; entries already in pipe still complete in order ahead of the err; nothing new accepted.
- cyc dropped with entries in flight: all pipe valids cleared on that edge; no late ack/err.
- stb with cyc low: protocol violation; one-cycle o_wb_err one cycle later, no RAM access, no state change.
- Stall injector: counter 0..STALL_PERIOD-1 advancing each cycle cyc is high, cleared when cyc low; o_wb_stall=1 when counter==STALL_PERIOD-1 or state==FAULT.
- o_wb_data holds last read value when not acking; write acks carry don't-care data (implementation drives last read value).

## Timing
- Reset: o_wb_stall=0, o_wb_ack=0, o_wb_err=0, o_wb_data=0, pipe cleared, state IDLE, stall counter 0. RAM contents not reset.
- Reset mid-transaction: pending acks discarded; no ack/err in cycle after reset.
- Latency: request accepted at edge T yields ack/err at edge T+ACK_DELAY, one per cycle, throughput one per cycle absent stalls.
- Read-after-write to same address on consecutive accepts returns new data.
- Write and read-err in same cycle cannot occur (single request per cycle).
- Simultaneous cyc fall and pipe-output valid: output suppressed.
- Address arithmetic: only bits [MAW-1:0] index RAM; no wrap beyond array since out-of-window is decoded as err.

## Structure
- Shared package: state encoding (IDLE/BUSY/FAULT), pipeline entry record {valid, err, data[31:0]}, ACK_DELAY range check constant.
- One sub-module: wbram_array, single-port synchronous RAM (2^MAW × 32, write-first). Decode, FSM, stall injector, and ack pipe stay in the top.

## Test plan
- Reset then write 0xDEADBEEF to addr 0x0008005, read back with ACK_DELAY=1 -> ack one cycle after each accept, read data 0xDEADBEEF.
- Burst of 8 pipelined reads, ACK_DELAY=3, STALL_PERIOD=4 -> stall every 4th cycle while cyc high, 8 acks in order, each 3 cycles after its accept.
- Read addr 0x0010000 (window bits ≠ BASE) after two valid reads -> two acks then one err; stall held high until cyc drops; next cycle after cyc low stall=0, state IDLE.
- Drop cyc with 2 requests in flight (ACK_DELAY=4) -> no ack or err afterward; RAM shows writes accepted before drop committed.
- stb=1, cyc=0 for one cycle -> o_wb_err pulse one cycle later, RAM unchanged, ack stays 0.
- Assert i_reset with 3 acks pending -> all outputs 0 next cycle, no stray ack after reset release.

Source files
------------

// File: rtl/wbram_decode_pkg.sv
// Shared definitions for the wbram_decode slave RAM.
//   state_t       : bus-cycle state (idle / busy / faulted)
//   pipe_entry_t  : one in-flight response {valid, err, data}
//   ack_delay_legal / stall_period_legal : parameter range checks
package wbram_decode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } pipe_entry_t;

    localparam int ACK_DELAY_MIN = 1;
    localparam int ACK_DELAY_MAX = 4;

    function automatic bit ack_delay_legal(input int d);
        return (d >= ACK_DELAY_MIN) && (d <= ACK_DELAY_MAX);
    endfunction

    // A period of 1 would stall every cycle and never accept anything.
    function automatic bit stall_period_legal(input int p);
        return (p == 0) || (p >= 2);
    endfunction

endpackage

// File: rtl/wbram_array.sv
// Single-port synchronous RAM, 2^MAW x 32, write-first.
//   clk   : rising-edge clock
//   en    : access enable (read or write)
//   we    : 1 = write wdata to addr
//   addr  : word index
//   wdata : write data
//   rdata : registered read data (shows wdata on a write)
module wbram_array #(
    parameter int MAW = 15
) (
    input  logic           clk,
    input  logic           en,
    input  logic           we,
    input  logic [MAW-1:0] addr,
    input  logic [31:0]    wdata,
    output logic [31:0]    rdata
);

    logic [31:0] mem [0:(1<<MAW)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata     <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/wbram_decode.sv
// Pipelined Wishbone slave RAM with address-window decode.
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_wb_cyc/stb/we      : bus cycle, strobe, write enable
//   i_wb_addr, i_wb_data : word address, write data
//   o_wb_stall           : request not accepted this cycle
//   o_wb_ack, o_wb_err   : in-order completion / fault
//   o_wb_data            : read data with ack, else last read value
//   o_dbg_state          : current state_t encoding
// Handshake: a request is taken on a rising edge where cyc & stb & !stall;
// each taken request gets exactly one ack or err ACK_DELAY edges later
// unless cyc drops (or reset) first, which discards everything in flight.
module wbram_decode
    import wbram_decode_pkg::*;
#(
    parameter int                AW           = 28,
    parameter int                MAW          = 15,
    parameter logic [AW-MAW-1:0] BASE         = (AW-MAW)'(1),
    parameter int                ACK_DELAY    = 1,
    parameter int                STALL_PERIOD = 0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [31:0]   i_wb_data,
    output logic          o_wb_stall,
    output logic          o_wb_ack,
    output logic          o_wb_err,
    output logic [31:0]   o_wb_data,
    output logic [1:0]    o_dbg_state
);

    if (!ack_delay_legal(ACK_DELAY) || !stall_period_legal(STALL_PERIOD)) begin : g_bad_param
        $error("wbram_decode: ACK_DELAY must be 1..4 and STALL_PERIOD 0 or >= 2");
    end

    localparam int CW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [CW-1:0] STALL_LAST = CW'((STALL_PERIOD > 1) ? STALL_PERIOD - 1 : 0);

    state_t               state, state_next;
    pipe_entry_t          pipe [ACK_DELAY];
    logic [ACK_DELAY-1:0] pipe_rd;       // entry is an in-window read
    pipe_entry_t          tail;
    logic [31:0]          ram_rdata;
    logic [31:0]          last_rd;
    logic                 viol;
    logic [CW-1:0]        stall_cnt;
    logic                 in_window;
    logic                 accept;
    logic                 inject;

    assign in_window = (i_wb_addr[AW-1:MAW] == BASE);
    assign inject    = (STALL_PERIOD > 1) && (stall_cnt == STALL_LAST);
    assign o_wb_stall = inject || (state == ST_FAULT);
    assign accept    = i_wb_cyc && i_wb_stb && !o_wb_stall;

    wbram_array #(.MAW(MAW)) u_array (
        .clk   (i_clk),
        .en    (accept && in_window && !i_reset),
        .we    (i_wb_we),
        .addr  (i_wb_addr[MAW-1:0]),
        .wdata (i_wb_data),
        .rdata (ram_rdata)
    );

    // Stage 0 cannot hold its own read data: the RAM register is loaded on
    // the same edge, so stage 0's data lives in ram_rdata and stage 1 copies it.
    always_comb begin
        tail = pipe[ACK_DELAY-1];
        if (ACK_DELAY == 1) begin
            tail.data = ram_rdata;
        end
    end

    // Gating with cyc suppresses a response the master has already abandoned.
    assign o_wb_ack  = tail.valid && !tail.err && i_wb_cyc;
    assign o_wb_err  = (tail.valid && tail.err && i_wb_cyc) || viol;
    assign o_wb_data = (o_wb_ack && pipe_rd[ACK_DELAY-1]) ? tail.data : last_rd;
    assign o_dbg_state = state;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < ACK_DELAY; k++) begin
                pipe[k] <= '0;
            end
            pipe_rd <= '0;
            viol    <= 1'b0;
            last_rd <= '0;
        end else begin
            viol <= i_wb_stb && !i_wb_cyc;
            if (o_wb_ack && pipe_rd[ACK_DELAY-1]) begin
                last_rd <= tail.data;
            end
            if (!i_wb_cyc) begin
                for (int k = 0; k < ACK_DELAY; k++) begin
                    pipe[k] <= '0;
                end
                pipe_rd <= '0;
            end else begin
                pipe[0]    <= '{valid: accept, err: !in_window, data: '0};
                pipe_rd[0] <= accept && in_window && !i_wb_we;
                for (int k = 1; k < ACK_DELAY; k++) begin
                    pipe[k].valid <= pipe[k-1].valid;
                    pipe[k].err   <= pipe[k-1].err;
                    pipe[k].data  <= (k == 1) ? ram_rdata : pipe[k-1].data;
                    pipe_rd[k]    <= pipe_rd[k-1];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || !i_wb_cyc) begin
            stall_cnt <= '0;
        end else if (STALL_PERIOD > 1) begin
            stall_cnt <= (stall_cnt == STALL_LAST) ? '0 : stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!i_wb_cyc) begin
            state_next = ST_IDLE;
        end else if ((accept && !in_window) || (state == ST_FAULT)) begin
            state_next = ST_FAULT;
        end else begin
            state_next = ST_BUSY;
        end
    end

endmodule

// File: tb/tb_wbram_decode.sv
`timescale 1ns/1ps
module tb_wbram_decode;
    import wbram_decode_pkg::*;

    localparam int NI = 3;

    function automatic int dly(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 4;
    endfunction

    function automatic int per(input int k);
        return (k == 1) ? 4 : 0;
    endfunction

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [NI];
    logic        cyc   [NI];
    logic        stb   [NI];
    logic        we    [NI];
    logic [27:0] addr  [NI];
    logic [31:0] wdat  [NI];
    logic        stall [NI];
    logic        ack   [NI];
    logic        err   [NI];
    logic [31:0] rdat  [NI];
    logic [1:0]  st    [NI];

    wbram_decode #(.ACK_DELAY(1), .STALL_PERIOD(0)) u0 (
        .i_clk(clk), .i_reset(rst[0]), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]),
        .i_wb_we(we[0]), .i_wb_addr(addr[0]), .i_wb_data(wdat[0]),
        .o_wb_stall(stall[0]), .o_wb_ack(ack[0]), .o_wb_err(err[0]),
        .o_wb_data(rdat[0]), .o_dbg_state(st[0]));

    wbram_decode #(.ACK_DELAY(3), .STALL_PERIOD(4)) u1 (
        .i_clk(clk), .i_reset(rst[1]), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]),
        .i_wb_we(we[1]), .i_wb_addr(addr[1]), .i_wb_data(wdat[1]),
        .o_wb_stall(stall[1]), .o_wb_ack(ack[1]), .o_wb_err(err[1]),
        .o_wb_data(rdat[1]), .o_dbg_state(st[1]));

    wbram_decode #(.ACK_DELAY(4), .STALL_PERIOD(0)) u2 (
        .i_clk(clk), .i_reset(rst[2]), .i_wb_cyc(cyc[2]), .i_wb_stb(stb[2]),
        .i_wb_we(we[2]), .i_wb_addr(addr[2]), .i_wb_data(wdat[2]),
        .o_wb_stall(stall[2]), .o_wb_ack(ack[2]), .o_wb_err(err[2]),
        .o_wb_data(rdat[2]), .o_dbg_state(st[2]));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model + compare ----------------
    // Responses are scheduled into a ring of future cycle slots.
    bit          s_valid [NI][8];
    bit          s_err   [NI][8];
    bit          s_rd    [NI][8];
    bit          s_known [NI][8];
    logic [31:0] s_data  [NI][8];
    logic [31:0] m_mem   [NI][32768];
    bit          m_known [NI][32768];
    int          m_ccount [NI];
    bit          m_fault  [NI];
    bit          m_viol   [NI];
    logic [31:0] m_last   [NI];
    bit          m_lknown [NI];
    logic [1:0]  m_state  [NI];
    int          ack_cnt  [NI];
    int          err_cnt  [NI];
    bit          live = 1'b0;

    initial begin
        int c;
        c = 0;
        for (int k = 0; k < NI; k++) begin
            for (int j = 0; j < 8; j++) s_valid[k][j] = 1'b0;
            ack_cnt[k] = 0;
            err_cnt[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                int  sl;
                bit  e_stall, e_ack, e_err, d_known;
                logic [31:0] e_data;
                sl      = c % 8;
                e_stall = ((per(k) >= 2) && ((m_ccount[k] % per(k)) == per(k) - 1)) || m_fault[k];
                e_ack   = s_valid[k][sl] && !s_err[k][sl] && (cyc[k] === 1'b1);
                e_err   = (s_valid[k][sl] && s_err[k][sl] && (cyc[k] === 1'b1)) || m_viol[k];
                e_data  = (e_ack && s_rd[k][sl]) ? s_data[k][sl] : m_last[k];
                d_known = (e_ack && s_rd[k][sl]) ? s_known[k][sl] : m_lknown[k];
                if (live) begin
                    chk($sformatf("u%0d_stall c%0d", k, c), 32'(stall[k]), 32'(e_stall));
                    chk($sformatf("u%0d_ack c%0d", k, c), 32'(ack[k]), 32'(e_ack));
                    chk($sformatf("u%0d_err c%0d", k, c), 32'(err[k]), 32'(e_err));
                    chk($sformatf("u%0d_state c%0d", k, c), 32'(st[k]), 32'(m_state[k]));
                    if (d_known) chk($sformatf("u%0d_data c%0d", k, c), rdat[k], e_data);
                    if (ack[k] === 1'b1) ack_cnt[k]++;
                    if (err[k] === 1'b1) err_cnt[k]++;
                end
                // Advance with the inputs the coming rising edge will sample.
                if (rst[k] === 1'b1) begin
                    for (int j = 0; j < 8; j++) s_valid[k][j] = 1'b0;
                    m_fault[k] = 1'b0; m_ccount[k] = 0; m_viol[k] = 1'b0;
                    m_last[k] = '0; m_lknown[k] = 1'b1; m_state[k] = ST_IDLE;
                end else begin
                    if (e_ack && s_rd[k][sl]) begin
                        m_last[k] = s_data[k][sl];
                        m_lknown[k] = s_known[k][sl];
                    end
                    m_viol[k] = stb[k] && !cyc[k];
                    s_valid[k][sl] = 1'b0;
                    if (!cyc[k]) begin
                        for (int j = 0; j < 8; j++) s_valid[k][j] = 1'b0;
                        m_ccount[k] = 0; m_fault[k] = 1'b0; m_state[k] = ST_IDLE;
                    end else begin
                        if (stb[k] && !e_stall) begin
                            bit inw;
                            int ns;
                            inw = (addr[k][27:15] == 13'd1);
                            ns  = (c + dly(k)) % 8;
                            s_valid[k][ns] = 1'b1;
                            s_err[k][ns]   = !inw;
                            s_rd[k][ns]    = inw && !we[k];
                            s_data[k][ns]  = m_mem[k][addr[k][14:0]];
                            s_known[k][ns] = m_known[k][addr[k][14:0]];
                            if (inw && we[k]) begin
                                m_mem[k][addr[k][14:0]]   = wdat[k];
                                m_known[k][addr[k][14:0]] = 1'b1;
                            end
                            if (!inw) m_fault[k] = 1'b1;
                        end
                        m_ccount[k]++;
                        m_state[k] = m_fault[k] ? ST_FAULT : ST_BUSY;
                    end
                end
            end
            if (rst[0] === 1'b1) live = 1'b1;
            c++;
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers start and end 1 ns after a rising edge.
    task automatic idle_cycles(input int k, input bit c, input int n);
        cyc[k] = c;
        stb[k] = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic bus_req(input int k, input bit w, input logic [27:0] a, input logic [31:0] d);
        bit done;
        done = 1'b0;
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; addr[k] = a; wdat[k] = d;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            done = (stall[k] === 1'b0);
            @(posedge clk); #1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL u%0d_req_timeout: got stalled expected accept within 8 cycles", k);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int a0, e0;
        logic [7:0] pat;
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            addr[k] = '0; wdat[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst_stall u%0d", k), 32'(stall[k]), 32'd0);
            chk($sformatf("rst_ack u%0d", k), 32'(ack[k]), 32'd0);
            chk($sformatf("rst_err u%0d", k), 32'(err[k]), 32'd0);
            chk($sformatf("rst_data u%0d", k), rdat[k], 32'd0);
        end
        @(posedge clk); #1;

        // Write then read back, one-cycle latency.
        bus_req(0, 1'b1, 28'h0008005, 32'hDEADBEEF);
        bus_req(0, 1'b0, 28'h0008005, 32'h0);
        stb[0] = 1'b0;
        @(negedge clk);
        chk("u0_rd_ack", 32'(ack[0]), 32'd1);
        chk("u0_rd_data", rdat[0], 32'hDEADBEEF);
        @(posedge clk); #1;
        idle_cycles(0, 1'b0, 2);

        // Two good reads then an out-of-window read.
        a0 = ack_cnt[0]; e0 = err_cnt[0];
        bus_req(0, 1'b0, 28'h0008005, 32'h0);
        bus_req(0, 1'b0, 28'h0008005, 32'h0);
        bus_req(0, 1'b0, 28'h0010000, 32'h0);
        idle_cycles(0, 1'b1, 4);
        @(negedge clk);
        chk("fault_stall_held", 32'(stall[0]), 32'd1);
        chk("fault_state", 32'(st[0]), 32'(ST_FAULT));
        chk("fault_acks", 32'(ack_cnt[0] - a0), 32'd2);
        chk("fault_errs", 32'(err_cnt[0] - e0), 32'd1);
        @(posedge clk); #1;
        idle_cycles(0, 1'b0, 1);
        @(negedge clk);
        chk("fault_release_stall", 32'(stall[0]), 32'd0);
        chk("fault_release_state", 32'(st[0]), 32'(ST_IDLE));
        @(posedge clk); #1;

        // Strobe without cycle: err pulse, RAM untouched.
        cyc[0] = 1'b0; stb[0] = 1'b1; we[0] = 1'b1;
        addr[0] = 28'h0008005; wdat[0] = 32'h12345678;
        @(posedge clk); #1;
        stb[0] = 1'b0;
        @(negedge clk);
        chk("viol_err", 32'(err[0]), 32'd1);
        chk("viol_ack", 32'(ack[0]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("viol_err_clear", 32'(err[0]), 32'd0);
        @(posedge clk); #1;
        bus_req(0, 1'b0, 28'h0008005, 32'h0);
        stb[0] = 1'b0;
        @(negedge clk);
        chk("viol_ram_kept", rdat[0], 32'hDEADBEEF);
        @(posedge clk); #1;
        idle_cycles(0, 1'b0, 2);

        // Stall injection pattern, period 4.
        cyc[1] = 1'b1; stb[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pat[i] = stall[1];
        end
        @(posedge clk); #1;
        chk("stall_pattern", 32'(pat), 32'h88);
        idle_cycles(1, 1'b0, 1);

        // Burst of 8 pipelined reads, delay 3, stalls every 4th cycle.
        for (int i = 0; i < 8; i++) bus_req(1, 1'b1, 28'h0008100 + 28'(i), 32'hA0000000 + 32'(i));
        idle_cycles(1, 1'b0, 2);
        a0 = ack_cnt[1];
        for (int i = 0; i < 8; i++) bus_req(1, 1'b0, 28'h0008100 + 28'(i), 32'h0);
        idle_cycles(1, 1'b1, 5);
        chk("burst_acks", 32'(ack_cnt[1] - a0), 32'd8);
        chk("burst_last_data", rdat[1], 32'hA0000007);
        idle_cycles(1, 1'b0, 2);

        // Drop cyc with two writes in flight, delay 4.
        a0 = ack_cnt[2]; e0 = err_cnt[2];
        bus_req(2, 1'b1, 28'h0008200, 32'h11110000);
        bus_req(2, 1'b1, 28'h0008201, 32'h22220000);
        idle_cycles(2, 1'b0, 6);
        chk("drop_no_ack", 32'(ack_cnt[2] - a0), 32'd0);
        chk("drop_no_err", 32'(err_cnt[2] - e0), 32'd0);
        a0 = ack_cnt[2];
        bus_req(2, 1'b0, 28'h0008200, 32'h0);
        bus_req(2, 1'b0, 28'h0008201, 32'h0);
        idle_cycles(2, 1'b1, 5);
        chk("drop_readback_acks", 32'(ack_cnt[2] - a0), 32'd2);
        chk("drop_readback_data", rdat[2], 32'h22220000);
        idle_cycles(2, 1'b0, 2);

        // Reset with three reads pending.
        bus_req(2, 1'b0, 28'h0008200, 32'h0);
        bus_req(2, 1'b0, 28'h0008201, 32'h0);
        bus_req(2, 1'b0, 28'h0008200, 32'h0);
        stb[2] = 1'b0; rst[2] = 1'b1;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        @(negedge clk);
        chk("rstp_ack", 32'(ack[2]), 32'd0);
        chk("rstp_err", 32'(err[2]), 32'd0);
        chk("rstp_stall", 32'(stall[2]), 32'd0);
        chk("rstp_data", rdat[2], 32'd0);
        @(posedge clk); #1;
        a0 = ack_cnt[2]; e0 = err_cnt[2];
        idle_cycles(2, 1'b1, 6);
        chk("rstp_no_stray_ack", 32'(ack_cnt[2] - a0), 32'd0);
        chk("rstp_no_stray_err", 32'(err_cnt[2] - e0), 32'd0);
        idle_cycles(2, 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected sequence end");
        $fatal(1, "watchdog");
    end

endmodule
